// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types and helpers for the lfsr_stream generator.
// Holds the topology and FSM enums, the tap bit-reverse helper and the
// warm-up counter width helper.
package lfsr_pkg;

   typedef enum logic {
      LFSR_GALOIS    = 1'b0,
      LFSR_FIBONACCI = 1'b1
   } lfsr_mode_e;

   typedef enum logic {
      WARM = 1'b0,
      RUN  = 1'b1
   } lfsr_state_e;

   // Widest LFSR the bit-reverse helper handles.
   localparam int LFSR_MAX_W = 64;
   localparam int LFSR_IDX_W = 6;

   // Warm-up counter width: enough to hold WARMUP, never less than 1 bit.
   function automatic int lfsr_cnt_width(input int warmup);
      int w;
      w = $clog2(warmup + 1);
      return (w < 1) ? 1 : w;
   endfunction

   // Reverse the low 'width' bits of v; bits above 'width' come back zero.
   function automatic logic [LFSR_MAX_W-1:0] bitrev(input logic [LFSR_MAX_W-1:0] v,
                                                    input int width);
      logic [LFSR_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < LFSR_MAX_W; i++) begin
         if (i < width) begin
            r[LFSR_IDX_W'(width - 1 - i)] = v[LFSR_IDX_W'(i)];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: one combinational single-bit LFSR advance.
// Galois shifts right and folds the taps in when the LSB is set; Fibonacci
// shifts right and inserts the parity of the tapped bits at the MSB.
// In both topologies the emitted bit is the LSB before the shift.
module lfsr_step
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
   parameter lfsr_mode_e       MODE  = LFSR_GALOIS
) (
   input  logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] next,
   output logic             out_bit
);

   assign out_bit = s[0];

   generate
      if (MODE == LFSR_GALOIS) begin : g_galois
         // Galois: shift, then xor the polynomial in when the outgoing bit is 1.
         assign next = (s >> 1) ^ ({WIDTH{s[0]}} & TAPS);
      end else begin : g_fibonacci
         // Taps are mirrored so that x^(i+1) lines up with the shift direction.
         localparam logic [LFSR_MAX_W-1:0] TAPS_EXT = LFSR_MAX_W'(TAPS);
         localparam logic [LFSR_MAX_W-1:0] REV_EXT  = bitrev(TAPS_EXT, WIDTH);
         localparam logic [WIDTH-1:0]      TAPS_REV = REV_EXT[WIDTH-1:0];
         // Fibonacci: feedback parity enters at the MSB.
         assign next = {^(s & TAPS_REV), s[WIDTH-1:1]};
      end
   endgenerate

endmodule

// File: rtl/lfsr_stream.sv
// lfsr_stream: parametrised multi-bit LFSR source with seed load, warm-up
// gating of 'valid' and all-zero lockup indication.
// Optional feature macro: LFSR_LOCKUP_RECOVER_EN (zero loads are replaced by
// SEED and 'lockup' becomes a one-cycle pulse). Without it, zero is loaded as
// given and 'lockup' is a level while the state is zero.
//
// Control: 'load' and 'en' are single-cycle strobes sampled on every rising
// clk edge with no back-pressure; 'load' wins over 'en'. 'valid' is a status
// level meaning the warm-up is over and lfsr_out/rnd_out are usable.
module lfsr_stream
   import lfsr_pkg::*;
#(
   parameter int               WIDTH  = 16,
   parameter logic [WIDTH-1:0] TAPS   = 16'hB400,
   parameter logic [WIDTH-1:0] SEED   = 16'hACE1,
   parameter lfsr_mode_e       MODE   = LFSR_GALOIS,
   parameter int               STEP   = 1,
   parameter int               WARMUP = 0
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] lfsr_out,
   output logic [STEP-1:0]  rnd_out,
   output logic             valid,
   output logic             lockup,
   output lfsr_state_e      fsm_state
);

   localparam int          CNT_W     = lfsr_cnt_width(WARMUP);
   localparam logic [CNT_W-1:0] WARMUP_C = CNT_W'(WARMUP);
   localparam lfsr_state_e FSM_START = (WARMUP == 0) ? RUN : WARM;

   logic [WIDTH-1:0] state_q, state_d;
   logic [STEP-1:0]  rnd_q, rnd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   lfsr_state_e      fsm_q, fsm_d;
   logic             lock_q, lock_d;
   logic [WIDTH-1:0] load_state;

   // STEP single steps chained; chain[k] is the state before step k.
   logic [WIDTH-1:0] chain [STEP+1];
   logic [STEP-1:0]  step_bits;

   assign chain[0] = state_q;

   generate
      for (genvar k = 0; k < STEP; k++) begin : g_step
         lfsr_step #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS),
            .MODE  (MODE)
         ) u_step (
            .s       (chain[k]),
            .next    (chain[k+1]),
            .out_bit (step_bits[k])
         );
      end
   endgenerate

`ifdef LFSR_LOCKUP_RECOVER_EN
   // A zero seed would lock the register; substitute the recovery seed.
   assign load_state = (load_val == '0) ? SEED : load_val;
`else
   assign load_state = load_val;
`endif

   // FSM register: WARM until the warm-up count of enabled cycles elapses.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         fsm_q <= FSM_START;
      end else begin
         fsm_q <= fsm_d;
      end
   end

   // FSM next state: load restarts warm-up; the last counted enable enters RUN.
   always_comb begin
      fsm_d = fsm_q;
      if (load) begin
         fsm_d = FSM_START;
      end else if (en && (fsm_q == WARM) && (cnt_q == CNT_W'(1))) begin
         fsm_d = RUN;
      end
   end

   // Datapath next values: state, output bits, warm-up counter, lockup flag.
   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      cnt_d   = cnt_q;
      if (load) begin
         state_d = load_state;
         rnd_d   = '0;
         cnt_d   = WARMUP_C;
      end else if (en) begin
         state_d = chain[STEP];
         rnd_d   = step_bits;
         // One decrement per enabled cycle, saturating at zero.
         if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
`ifdef LFSR_LOCKUP_RECOVER_EN
      lock_d = load && (load_val == '0);
`else
      lock_d = (state_d == '0);
`endif
   end

   // Datapath registers; reset restores the seed with no partial step.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= SEED;
         rnd_q   <= '0;
         cnt_q   <= WARMUP_C;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         cnt_q   <= cnt_d;
         lock_q  <= lock_d;
      end
   end

   assign lfsr_out  = state_q;
   assign rnd_out   = rnd_q;
   assign valid     = (fsm_q == RUN);
   assign lockup    = lock_q;
   assign fsm_state = fsm_q;

endmodule
